// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with stuck-input detection
// Synchronizes pwm_in, times rising-to-rising and rising-to-falling intervals, and flags silence.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_lat_q, hi_lat_d, idle_q, idle_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, level_q, level_d;
  logic             rise, fall, edge_seen;
  logic [CNT_W-1:0] cnt_inc, idle_inc;

  always_comb begin
    s1_d      = pwm_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    idle_d    = idle_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    level_d   = level_q;
    rise      = s2_q & ~s3_q;
    fall      = ~s2_q & s3_q;
    edge_seen = rise | fall;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    idle_inc  = (idle_q == CNT_MAX) ? idle_q : idle_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = LOW;
        end
      end
      LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_lat_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge in the timeout cycle takes priority, so stuck is never raised alongside an edge.
    if (edge_seen) begin
      idle_d  = '0;
      stuck_d = 1'b0;
    end else begin
      idle_d = idle_inc;
      if (idle_q == TO_LAST) begin
        stuck_d = 1'b1;
        level_d = s2_q;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      idle_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      idle_q   <= idle_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign period_count = period_q;
  assign high_count   = high_q;
  assign meas_valid   = valid_q;
  assign stuck        = stuck_q;
  assign stuck_level  = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
// Instance a is the main DUT; instance b (8-bit counters) covers period saturation.
module tb_pwm_capture;
  localparam int T_A = 4500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] pc_a, hc_a;
  logic        mv_a, st_a, sl_a;
  logic [7:0]  pc_b, hc_b;
  logic        mv_b, st_b, sl_b;

  pwm_capture #(.CNT_W(16), .TIMEOUT(T_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
    .period_count(pc_a), .high_count(hc_a), .meas_valid(mv_a),
    .stuck(st_a), .stuck_level(sl_a)
  );

  pwm_capture #(.CNT_W(8), .TIMEOUT(200)) dut_b (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
    .period_count(pc_b), .high_count(hc_b), .meas_valid(mv_b),
    .stuck(st_b), .stuck_level(sl_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int h;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_p = 0;
  int   last_h = 0;
  int   armed = 0;
  int   last_edge = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, want);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // A rise reports the period that ended with it, three clock edges later.
  task automatic drive_rise();
    exp_t e;
    if (armed != 0) begin
      e.p  = last_p;
      e.h  = last_h;
      e.at = cyc + 3;
      sb.push_back(e);
    end
    pwm_in    = 1'b1;
    last_edge = cyc;
  endtask

  task automatic finish_period(input int p, input int h, input int elapsed);
    repeat (h - elapsed) tick();
    pwm_in    = 1'b0;
    last_edge = cyc;
    repeat (p - h) tick();
    last_p = p;
    last_h = h;
    armed  = 1;
  endtask

  task automatic drive_period(input int p, input int h);
    drive_rise();
    finish_period(p, h, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && sb[0].at < cyc) begin
      check("valid_late", 32'(cyc), 32'(sb[0].at));
      void'(sb.pop_front());
    end
    if (mv_a === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(mv_a), 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", 32'(cyc), 32'(e.at));
        check("period_count", 32'(pc_a), 32'(e.p));
        check("high_count", 32'(hc_a), 32'(e.h));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) tick();
    check("rst_period", 32'(pc_a), 32'd0);
    check("rst_high", 32'(hc_a), 32'd0);
    check("rst_valid", 32'(mv_a), 32'd0);
    check("rst_stuck", 32'(st_a), 32'd0);
    check("rst_level", 32'(sl_a), 32'd0);
    reset_n = 1'b1;
    tick();

    repeat (3) drive_period(100, 25);
    repeat (3) drive_period(4096, 200);
    repeat (8) drive_period(2, 1);

    // Held low: stuck lands exactly T_A edges after the last edge would have registered.
    while (cyc < last_edge + 2 + T_A) tick();
    check("stuck_lo_early", 32'(st_a), 32'd0);
    tick();
    check("stuck_lo", 32'(st_a), 32'd1);
    check("stuck_lo_level", 32'(sl_a), 32'd0);
    check("stuck_hold_period", 32'(pc_a), 32'd2);
    check("stuck_hold_high", 32'(hc_a), 32'd1);
    armed = 0;

    drive_rise();
    tick();
    tick();
    check("resume_still_stuck", 32'(st_a), 32'd1);
    tick();
    check("resume_cleared", 32'(st_a), 32'd0);
    finish_period(100, 25, 3);
    repeat (2) drive_period(100, 25);

    drive_rise();
    while (cyc < last_edge + 2 + T_A) tick();
    check("stuck_hi_early", 32'(st_a), 32'd0);
    tick();
    check("stuck_hi", 32'(st_a), 32'd1);
    check("stuck_hi_level", 32'(sl_a), 32'd1);
    check("stuck_hi_period", 32'(pc_a), 32'd100);
    armed = 0;

    pwm_in    = 1'b0;
    last_edge = cyc;
    repeat (3) tick();
    check("fall_clears_stuck", 32'(st_a), 32'd0);
    while (cyc < last_edge + T_A) tick();
    pwm_in = 1'b1;
    repeat (3) tick();
    check("edge_beats_timeout", 32'(st_a), 32'd0);
    finish_period(100, 25, 3);
    drive_period(100, 25);

    drive_rise();
    repeat (10) tick();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    tick();
    check("midrst_period", 32'(pc_a), 32'd0);
    check("midrst_high", 32'(hc_a), 32'd0);
    check("midrst_valid", 32'(mv_a), 32'd0);
    check("midrst_stuck", 32'(st_a), 32'd0);
    tick();
    reset_n = 1'b1;
    armed   = 0;
    repeat (5) tick();
    repeat (2) drive_period(100, 25);

    drive_rise();
    repeat (5) tick();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    armed   = 0;
    tick();
    repeat (2) drive_period(300, 150);
    drive_rise();
    repeat (3) tick();
    check("sat_valid", 32'(mv_b), 32'd1);
    check("sat_period", 32'(pc_b), 32'd255);
    check("sat_high", 32'(hc_b), 32'd150);
    pwm_in = 1'b0;
    repeat (20) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
